mips_trace_monitor: RTL and testbench
=====================================

MIPS_TRACE_MONITOR -- requirements
Module: mips_trace_monitor

Interface
REQ-001 Parameter DATA_W, 32, width of each observed debug channel.
REQ-002 Parameter DEPTH, 8, trace entries; power of two, 2..256.
REQ-003 Parameter HALT_CYCLES, 4, consecutive identical PC samples that declare a halt; 2..255.
REQ-004 Parameter TIMEOUT, 1024, capture-cycle budget before forced stop; 1..2^20.
REQ-005 Parameter WRAP_MODE, 1: 1 = overwrite oldest when full, 0 = stop when full.
REQ-006 clk  in  1  single system clock; all state changes on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle pulse; arms capture from IDLE.
REQ-009 sample_en  in  1  core-running qualifier; a sample is taken only when high.
REQ-010 pc_in  in  DATA_W  core debug PC.
REQ-011 alu_in  in  DATA_W  core debug ALU result.
REQ-012 mem_in  in  DATA_W  core debug data-memory read value.
REQ-013 rd_ready  in  1  readout consumer accepts the current entry.
REQ-014 rd_valid  out  1  rd_pc/rd_alu/rd_mem hold a valid entry.
REQ-015 rd_pc, rd_alu, rd_mem  out  DATA_W each  entry fields, oldest first.
REQ-016 entries  out  clog2(DEPTH)+1  number of valid stored entries.
REQ-017 busy  out  1  high in CAPTURE or READOUT.
REQ-018 halted, timed_out, full_stop  out  1 each  sticky stop-cause flags.
REQ-019 cycle_cnt  out  21  sampled cycles since the accepted start.

Function
REQ-020 FSM states IDLE, CAPTURE, READOUT; start in IDLE moves to CAPTURE next edge, clears entries, pointers, cycle_cnt and all flags.
REQ-021 start outside IDLE shall be ignored.
REQ-022 In CAPTURE, each cycle with sample_en=1 shall write {pc_in, alu_in, mem_in} at wr_ptr on that edge, advance wr_ptr modulo DEPTH, and increment cycle_cnt.
REQ-023 entries saturates at DEPTH; in WRAP_MODE=1 a write when full also advances rd_ptr (oldest dropped).
REQ-024 In WRAP_MODE=0 the write that makes entries=DEPTH shall set full_stop and move to READOUT next edge.
REQ-025 Halt: a sample whose pc_in equals the previously captured PC increments a repeat counter, otherwise the counter resets to 0; on the sample where repeats reach HALT_CYCLES-1, halted sets and FSM moves to READOUT; that sample is stored.
REQ-026 Timeout: the sample making cycle_cnt equal TIMEOUT sets timed_out and moves to READOUT; that sample is stored.
REQ-027 Simultaneous stop causes on one sample shall set every applicable flag; single transition to READOUT.
REQ-028 Cycles with sample_en=0 shall neither store nor count, nor reset the repeat counter.
REQ-029 In READOUT, rd_valid=1 while entries>0; rd_* present the entry at rd_ptr combinationally from storage.
REQ-030 rd_valid&&rd_ready shall advance rd_ptr modulo DEPTH and decrement entries on that edge; rd_* shall hold stable while rd_valid&&!rd_ready.
REQ-031 When entries reaches 0 in READOUT (including 0 on entry), FSM returns to IDLE next edge; flags persist until next accepted start.
REQ-032 Capture inputs shall be ignored outside CAPTURE; rd_ready shall be ignored outside READOUT.

Reset
REQ-033 reset shall force IDLE, entries=0, pointers=0, cycle_cnt=0, repeat counter=0, rd_valid=0, busy=0, all flags 0; storage contents need not clear.
REQ-034 reset asserted mid-CAPTURE or mid-READOUT shall abort with the REQ-033 state on that edge and take priority over start.

Structure
REQ-035 Shared package mips_dbg_pkg holds the FSM state encoding and the stop-cause flag bit indices.
REQ-036 Storage shall be sub-module mips_trace_ram: DEPTH x 3*DATA_W register array, one synchronous write port, one combinational read port.

Verification (DEPTH=4, HALT_CYCLES=3, TIMEOUT=20)
REQ-037 start, PC 0,4,8,12,12,12 every cycle -> halted=1 after 6th sample; WRAP_MODE=1 readout 8,12,12,12; entries 4->0; IDLE.
REQ-038 WRAP_MODE=0, PC 0,4,8,12 -> full_stop=1, halted=0, readout 0,4,8,12 with matching alu/mem values.
REQ-039 PC incrementing by 4 for 20 samples -> timed_out=1, cycle_cnt=20; readout (wrap) PCs 64,68,72,76.
REQ-040 sample_en toggled 1,0,1,0 with PC 0,0,0,0 -> 2 samples stored, no halt; rd_ready held 0 three cycles -> rd_pc stable.
REQ-041 reset pulsed during READOUT after 1 accept -> next edge IDLE, entries=0, rd_valid=0, flags 0; start during CAPTURE ignored.

Source files
------------

// File: rtl/mips_dbg_pkg.sv
// ============================================================================
// Module      : mips_dbg_pkg
// Description : Shared FSM encoding and stop-cause flag indices for the
//               MIPS debug trace monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_READOUT = 2'd2
    } state_t;

    localparam int FLAG_HALT    = 0;
    localparam int FLAG_TIMEOUT = 1;
    localparam int FLAG_FULL    = 2;
    localparam int NUM_FLAGS    = 3;

endpackage

`default_nettype wire

// File: rtl/mips_trace_ram.sv
// ============================================================================
// Module      : mips_trace_ram
// Description : DEPTH x 3*DATA_W trace storage, synchronous write and
//               combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_trace_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [3*DATA_W-1:0]   i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [3*DATA_W-1:0]   o_rdata
);

    logic [3*DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/mips_trace_monitor.sv
// ============================================================================
// Module      : mips_trace_monitor
// Description : Captures PC/ALU/memory debug samples into a trace buffer,
//               stops on halt, timeout or full, then drains oldest-first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_trace_monitor
    import mips_dbg_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 8,
    parameter int HALT_CYCLES = 4,
    parameter int TIMEOUT     = 1024,
    parameter int WRAP_MODE   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      sample_en,
    input  logic [DATA_W-1:0]         pc_in,
    input  logic [DATA_W-1:0]         alu_in,
    input  logic [DATA_W-1:0]         mem_in,
    input  logic                      rd_ready,
    output logic                      rd_valid,
    output logic [DATA_W-1:0]         rd_pc,
    output logic [DATA_W-1:0]         rd_alu,
    output logic [DATA_W-1:0]         rd_mem,
    output logic [$clog2(DEPTH):0]    entries,
    output logic                      busy,
    output logic                      halted,
    output logic                      timed_out,
    output logic                      full_stop,
    output logic [20:0]               cycle_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    state_t                 r_state;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_entries;
    logic [20:0]            r_cycle_cnt;
    logic [7:0]             r_rep_cnt;
    logic [DATA_W-1:0]      r_last_pc;
    logic                   r_pc_valid;
    logic [NUM_FLAGS-1:0]   r_flags;

    logic                   w_we;
    logic [7:0]             w_rep_next;
    logic [NUM_FLAGS-1:0]   w_stop;
    logic [3*DATA_W-1:0]    w_rdata;
    logic                   w_full;

    assign w_we   = (r_state == ST_CAPTURE) && sample_en;
    assign w_full = (r_entries == CNT_W'(DEPTH));

    // Stop causes are evaluated on the sample being stored this cycle.
    always_comb begin
        w_rep_next = 8'd0;
        w_stop     = '0;
        if (r_pc_valid && (pc_in == r_last_pc)) begin
            w_rep_next = r_rep_cnt + 8'd1;
        end
        if (w_we) begin
            w_stop[FLAG_HALT]    = (w_rep_next == 8'(HALT_CYCLES - 1));
            w_stop[FLAG_TIMEOUT] = ((r_cycle_cnt + 21'd1) == 21'(TIMEOUT));
            w_stop[FLAG_FULL]    = (WRAP_MODE == 0) &&
                                   (r_entries == CNT_W'(DEPTH - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_entries   <= '0;
            r_cycle_cnt <= '0;
            r_rep_cnt   <= '0;
            r_last_pc   <= '0;
            r_pc_valid  <= 1'b0;
            r_flags     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_CAPTURE;
                        r_wr_ptr    <= '0;
                        r_rd_ptr    <= '0;
                        r_entries   <= '0;
                        r_cycle_cnt <= '0;
                        r_rep_cnt   <= '0;
                        r_pc_valid  <= 1'b0;
                        r_flags     <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (sample_en) begin
                        r_wr_ptr    <= r_wr_ptr + 1'b1;
                        r_cycle_cnt <= r_cycle_cnt + 21'd1;
                        r_rep_cnt   <= w_rep_next;
                        r_last_pc   <= pc_in;
                        r_pc_valid  <= 1'b1;
                        r_flags     <= r_flags | w_stop;
                        // A full buffer only receives writes in wrap mode; drop the oldest.
                        if (w_full) begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end else begin
                            r_entries <= r_entries + 1'b1;
                        end
                        if (|w_stop) begin
                            r_state <= ST_READOUT;
                        end
                    end
                end
                ST_READOUT: begin
                    if (r_entries == '0) begin
                        r_state <= ST_IDLE;
                    end else if (rd_ready) begin
                        r_rd_ptr  <= r_rd_ptr + 1'b1;
                        r_entries <= r_entries - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    mips_trace_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata ({pc_in, alu_in, mem_in}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign rd_valid  = (r_state == ST_READOUT) && (r_entries != '0);
    assign rd_pc     = w_rdata[3*DATA_W-1:2*DATA_W];
    assign rd_alu    = w_rdata[2*DATA_W-1:DATA_W];
    assign rd_mem    = w_rdata[DATA_W-1:0];
    assign entries   = r_entries;
    assign busy      = (r_state != ST_IDLE);
    assign halted    = r_flags[FLAG_HALT];
    assign timed_out = r_flags[FLAG_TIMEOUT];
    assign full_stop = r_flags[FLAG_FULL];
    assign cycle_cnt = r_cycle_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mips_trace_monitor.sv
// ============================================================================
// Module      : tb_mips_trace_monitor
// Description : Directed self-checking bench, one wrapping and one
//               stop-when-full instance sharing stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_trace_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sample_en = 1'b0;
    logic        rd_ready = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] alu_in = '0;
    logic [31:0] mem_in = '0;

    logic        rv_w, busy_w, halt_w, to_w, fs_w;
    logic [31:0] pc_w, alu_w, mem_w;
    logic [2:0]  ent_w;
    logic [20:0] cyc_w;
    logic        rv_s, busy_s, halt_s, to_s, fs_s;
    logic [31:0] pc_s, alu_s, mem_s;
    logic [2:0]  ent_s;
    logic [20:0] cyc_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_trace_monitor #(.DATA_W(32), .DEPTH(4), .HALT_CYCLES(3), .TIMEOUT(20), .WRAP_MODE(1)) dut_w (
        .clk(clk), .reset(reset), .start(start), .sample_en(sample_en),
        .pc_in(pc_in), .alu_in(alu_in), .mem_in(mem_in), .rd_ready(rd_ready),
        .rd_valid(rv_w), .rd_pc(pc_w), .rd_alu(alu_w), .rd_mem(mem_w),
        .entries(ent_w), .busy(busy_w), .halted(halt_w), .timed_out(to_w),
        .full_stop(fs_w), .cycle_cnt(cyc_w)
    );

    mips_trace_monitor #(.DATA_W(32), .DEPTH(4), .HALT_CYCLES(3), .TIMEOUT(20), .WRAP_MODE(0)) dut_s (
        .clk(clk), .reset(reset), .start(start), .sample_en(sample_en),
        .pc_in(pc_in), .alu_in(alu_in), .mem_in(mem_in), .rd_ready(rd_ready),
        .rd_valid(rv_s), .rd_pc(pc_s), .rd_alu(alu_s), .rd_mem(mem_s),
        .entries(ent_s), .busy(busy_s), .halted(halt_s), .timed_out(to_s),
        .full_stop(fs_s), .cycle_cnt(cyc_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [31:0] pc, input logic [31:0] alu,
                          input logic [31:0] mem, input logic en);
        pc_in = pc; alu_in = alu; mem_in = mem; sample_en = en;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic restart();
        reset = 1'b1; tick(); reset = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rd_ready = 1'b1; tick(); tick(); reset = 1'b0; tick(); rd_ready = 1'b0;
        n_checks++;
        if ({busy_w, rv_w, ent_w, halt_w, to_w, fs_w, cyc_w} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b rv=%b ent=%0d flags=%b%b%b cyc=%0d, required all 0",
                     busy_w, rv_w, ent_w, halt_w, to_w, fs_w, cyc_w);
        end
    endtask

    task automatic test_halt_wrap();
        logic [31:0] pcs [6] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd12, 32'd12};
        logic [31:0] exp [4] = '{32'd8, 32'd12, 32'd12, 32'd12};
        restart();
        n_checks++;
        if (busy_w !== 1'b1 || ent_w !== 3'd0) begin
            n_fail++; $display("FAIL start_capture: busy=%b ent=%0d, required 1/0", busy_w, ent_w);
        end
        for (int i = 0; i < 6; i++) sample(pcs[i], pcs[i] ^ 32'hA5A5_0000, pcs[i] + 32'h1000, 1'b1);
        n_checks++;
        if (halt_w !== 1'b1 || to_w !== 1'b0 || fs_w !== 1'b0 || ent_w !== 3'd4 || cyc_w !== 21'd6) begin
            n_fail++;
            $display("FAIL halt_stop: halt=%b to=%b fs=%b ent=%0d cyc=%0d, required 1/0/0/4/6",
                     halt_w, to_w, fs_w, ent_w, cyc_w);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rv_w !== 1'b1 || pc_w !== exp[i] || ent_w !== 3'(4 - i)) begin
                n_fail++;
                $display("FAIL halt_readout[%0d]: rv=%b pc=%0d ent=%0d, required 1/%0d/%0d",
                         i, rv_w, pc_w, ent_w, exp[i], 4 - i);
            end
            rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        end
        n_checks++;
        if (rv_w !== 1'b0 || ent_w !== 3'd0 || busy_w !== 1'b1) begin
            n_fail++; $display("FAIL halt_drained: rv=%b ent=%0d busy=%b, required 0/0/1", rv_w, ent_w, busy_w);
        end
        tick();
        n_checks++;
        if (busy_w !== 1'b0 || halt_w !== 1'b1) begin
            n_fail++; $display("FAIL halt_idle: busy=%b halt=%b, required 0/1", busy_w, halt_w);
        end
    endtask

    task automatic test_full_stop();
        restart();
        for (int i = 0; i < 4; i++) sample(32'(4 * i), 32'(4 * i) ^ 32'hA5A5_0000, 32'(4 * i) + 32'h1000, 1'b1);
        n_checks++;
        if (fs_s !== 1'b1 || halt_s !== 1'b0 || to_s !== 1'b0 || ent_s !== 3'd4 || rv_s !== 1'b1) begin
            n_fail++;
            $display("FAIL full_stop: fs=%b halt=%b to=%b ent=%0d rv=%b, required 1/0/0/4/1",
                     fs_s, halt_s, to_s, ent_s, rv_s);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (pc_s !== 32'(4 * i) || alu_s !== (32'(4 * i) ^ 32'hA5A5_0000) || mem_s !== 32'(4 * i) + 32'h1000) begin
                n_fail++;
                $display("FAIL full_readout[%0d]: pc=%h alu=%h mem=%h, required %h/%h/%h", i, pc_s, alu_s, mem_s,
                         32'(4 * i), 32'(4 * i) ^ 32'hA5A5_0000, 32'(4 * i) + 32'h1000);
            end
            rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        end
        tick();
        n_checks++;
        if (busy_s !== 1'b0 || fs_s !== 1'b1) begin
            n_fail++; $display("FAIL full_idle: busy=%b fs=%b, required 0/1", busy_s, fs_s);
        end
    endtask

    task automatic test_timeout();
        restart();
        for (int i = 0; i < 20; i++) begin
            sample(32'(4 * i), 32'(i), 32'(i + 7), 1'b1);
            if (i == 18) begin
                n_checks++;
                if (to_w !== 1'b0 || busy_w !== 1'b1 || cyc_w !== 21'd19) begin
                    n_fail++; $display("FAIL timeout_early: to=%b cyc=%0d, required 0/19", to_w, cyc_w);
                end
            end
        end
        n_checks++;
        if (to_w !== 1'b1 || cyc_w !== 21'd20 || halt_w !== 1'b0 || ent_w !== 3'd4) begin
            n_fail++;
            $display("FAIL timeout_stop: to=%b cyc=%0d halt=%b ent=%0d, required 1/20/0/4", to_w, cyc_w, halt_w, ent_w);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rv_w !== 1'b1 || pc_w !== 32'(64 + 4 * i)) begin
                n_fail++; $display("FAIL timeout_readout[%0d]: rv=%b pc=%0d, required 1/%0d", i, rv_w, pc_w, 64 + 4 * i);
            end
            tick();
        end
        rd_ready = 1'b0;
        tick();
    endtask

    task automatic test_sample_en();
        restart();
        sample(32'd0, 32'd100, 32'd200, 1'b1);
        sample(32'd0, 32'd101, 32'd201, 1'b0);
        sample(32'd0, 32'd102, 32'd202, 1'b1);
        sample(32'd0, 32'd103, 32'd203, 1'b0);
        n_checks++;
        if (ent_w !== 3'd2 || cyc_w !== 21'd2 || halt_w !== 1'b0 || busy_w !== 1'b1 || rv_w !== 1'b0) begin
            n_fail++;
            $display("FAIL sample_en_gate: ent=%0d cyc=%0d halt=%b busy=%b rv=%b, required 2/2/0/1/0",
                     ent_w, cyc_w, halt_w, busy_w, rv_w);
        end
        sample(32'd0, 32'd104, 32'd204, 1'b1);
        n_checks++;
        if (halt_w !== 1'b1 || ent_w !== 3'd3) begin
            n_fail++; $display("FAIL sample_en_halt: halt=%b ent=%0d, required 1/3", halt_w, ent_w);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rv_w !== 1'b1 || alu_w !== 32'd100 || mem_w !== 32'd200 || ent_w !== 3'd3) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: rv=%b alu=%0d mem=%0d ent=%0d, required 1/100/200/3",
                         i, rv_w, alu_w, mem_w, ent_w);
            end
            tick();
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (alu_w !== 32'(100 + 2 * i)) begin
                n_fail++; $display("FAIL stall_drain[%0d]: alu=%0d, required %0d", i, alu_w, 100 + 2 * i);
            end
            tick();
        end
        rd_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_readout();
        restart();
        sample(32'd0, 32'd1, 32'd2, 1'b1);
        start = 1'b1;
        sample(32'd0, 32'd3, 32'd4, 1'b1);
        start = 1'b0;
        n_checks++;
        if (ent_w !== 3'd2 || cyc_w !== 21'd2) begin
            n_fail++; $display("FAIL start_ignored: ent=%0d cyc=%0d, required 2/2", ent_w, cyc_w);
        end
        sample(32'd0, 32'd5, 32'd6, 1'b1);
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        n_checks++;
        if (ent_w !== 3'd2 || rv_w !== 1'b1 || halt_w !== 1'b1) begin
            n_fail++; $display("FAIL pre_abort: ent=%0d rv=%b halt=%b, required 2/1/1", ent_w, rv_w, halt_w);
        end
        reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
        n_checks++;
        if ({busy_w, rv_w, ent_w, halt_w, to_w, fs_w, cyc_w} !== '0) begin
            n_fail++;
            $display("FAIL abort_reset: busy=%b rv=%b ent=%0d flags=%b%b%b cyc=%0d, required all 0",
                     busy_w, rv_w, ent_w, halt_w, to_w, fs_w, cyc_w);
        end
    endtask

    initial begin
        test_reset();
        test_halt_wrap();
        test_full_stop();
        test_timeout();
        test_sample_en();
        test_reset_readout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
